// File: rtl/seq_div.sv
// seq_div: multi-cycle radix-2 restoring divider serving DIV/DIVU.
// Quotient goes to LO (q), remainder to HI (r). Operands are converted to
// magnitudes at start, divided over ITER steps, then sign-corrected.
// Optional build macro DIV_ZERO_FAST_EN: a zero divisor skips the
// iteration phase and goes straight to the fix-up state.
module seq_div #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Two's complement negate; |0x80000000| falls out as 0x80000000.
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return (~x) + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;        // dividend magnitude, becomes quotient
  logic [WIDTH-1:0] b_q, b_d;        // divisor magnitude
  logic [WIDTH:0]   rem_q, rem_d;    // partial remainder, one bit of headroom
  logic [4:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;    // raw dividend for the divide-by-zero result
  logic             bz_q, bz_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             dz_q, dz_d;
  logic [WIDTH:0]   rem_sh_s;

  // State register and all datapath/output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      cnt_q   <= 5'd0;
      dvd_q   <= '0;
      bz_q    <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      bz_q    <= bz_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
    end
  end

  // Next-state logic: latch operands, iterate one restoring step per cycle, fix up signs.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    bz_d     = bz_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    q_d      = q_q;
    r_d      = r_q;
    dz_d     = dz_q;
    rem_sh_s = {rem_q[WIDTH-1:0], a_q[WIDTH-1]};

    case (state_q)
      IDLE: begin
        if (start) begin
          dvd_d  = dividend;
          a_d    = (sign && dividend[WIDTH-1]) ? neg_w(dividend) : dividend;
          b_d    = (sign && divisor[WIDTH-1])  ? neg_w(divisor)  : divisor;
          rem_d  = '0;
          cnt_d  = 5'd0;
          bz_d   = (divisor == '0);
          qneg_d = sign && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          rneg_d = sign && dividend[WIDTH-1];
          busy_d = 1'b1;
`ifdef DIV_ZERO_FAST_EN
          state_d = (divisor == '0) ? FIX : CALC;
`else
          state_d = CALC;
`endif
        end else begin
          busy_d = 1'b0;
        end
      end
      CALC: begin
        // Quotient bits shift into a_q from the bottom as dividend bits leave the top.
        if (rem_sh_s >= {1'b0, b_q}) begin
          rem_d = rem_sh_s - {1'b0, b_q};
          a_d   = {a_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_sh_s;
          a_d   = {a_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(ITER - 1)) begin
          state_d = FIX;
        end else begin
          state_d = CALC;
        end
      end
      FIX: begin
        if (bz_q) begin
          q_d = '1;
          r_d = dvd_q;
        end else begin
          q_d = qneg_q ? neg_w(a_q) : a_q;
          r_d = rneg_q ? neg_w(rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];
        end
        dz_d    = bz_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign q        = q_q;
  assign r        = r_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: randomized and directed self-checking bench for seq_div.
// Reference results come from plain 64-bit integer arithmetic.
module tb_seq_div;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sign;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] q;
  logic [31:0] r;
  logic        div_zero;

  int n_checks = 0;
  int n_fail   = 0;

  seq_div dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sign     (sign),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .q        (q),
    .r        (r),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: truncating division, remainder follows dividend sign.
  task automatic model(input logic s, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eq, output logic [31:0] er, output logic ez);
    longint sa, sb, qq, rr;
    if (b == 32'd0) begin
      eq = 32'hFFFF_FFFF;
      er = a;
      ez = 1'b1;
    end else begin
      if (s) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'({32'd0, a});
        sb = longint'({32'd0, b});
      end
      qq = sa / sb;
      rr = sa % sb;
      eq = qq[31:0];
      er = rr[31:0];
      ez = 1'b0;
    end
  endtask

  function automatic int exp_latency(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
    return (b == 32'd0) ? 2 : 34;
`else
    return 34;
`endif
  endfunction

  // Called at a negedge; the start is sampled at the following posedge (edge k).
  // inj_at > 0 raises a second start (9/3) at that cycle, which must be ignored.
  task automatic run_div(input string tag, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input int inj_at);
    logic [31:0] eq, er;
    logic        ez;
    int          n, busy_cnt, lat;
    model(s, a, b, eq, er, ez);
    lat      = exp_latency(b);
    start    = 1'b1;
    sign     = s;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    sign     = 1'($urandom);
    n        = 1;
    busy_cnt = 0;
    while (!done && n < 60) begin
      if (busy) busy_cnt++;
      if (inj_at > 0 && n == inj_at) begin
        start    = 1'b1;
        sign     = 1'b0;
        dividend = 32'd9;
        divisor  = 32'd3;
      end else begin
        start    = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check({tag, " latency"}, 32'(n), 32'(lat));
    check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(lat - 1));
    check({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
    check({tag, " q"}, q, eq);
    check({tag, " r"}, r, er);
    check({tag, " div_zero"}, {31'd0, div_zero}, {31'd0, ez});
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    int          saw_done;

    rst_n    = 1'b0;
    start    = 1'b0;
    sign     = 1'b0;
    dividend = 32'd0;
    divisor  = 32'd0;
    repeat (3) @(negedge clk);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset q", q, 32'd0);
    check("reset r", r, 32'd0);
    check("reset div_zero", {31'd0, div_zero}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_div("u100_7", 1'b0, 32'd100, 32'd7, 0);
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("q_holds", q, 32'd14);

    run_div("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    run_div("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 0);
    run_div("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_div("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 0);
    run_div("s_div0", 1'b1, 32'h1234_5678, 32'd0, 0);
    run_div("u_div0_neg", 1'b0, 32'h8765_4321, 32'd0, 0);
    run_div("ignored_start", 1'b0, 32'd50, 32'd5, 9);
    // Back-to-back: each call starts in the done cycle of the previous one.
    run_div("b2b_first", 1'b1, 32'hFFFF_FF00, 32'd7, 0);
    run_div("b2b_second", 1'b0, 32'd1000, 32'd33, 0);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom);
      case ($urandom_range(0, 4))
        0: rb = 32'($urandom_range(1, 15));
        1: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 7));
        2: ra = 32'h8000_0000;
        3: if (i % 4 == 0) rb = 32'd0;
        default: ;
      endcase
      run_div($sformatf("rand%0d", i), rs, ra, rb, 0);
    end

    // Reset mid-operation: outputs clear at once and no done follows.
    @(negedge clk);
    start    = 1'b1;
    sign     = 1'b0;
    dividend = 32'd77;
    divisor  = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    check("abort q", q, 32'd0);
    check("abort r", r, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (done || busy) saw_done++;
    end
    check("abort no_done", 32'(saw_done), 32'd0);

    // Operation resumes normally after the aborted one.
    run_div("after_abort", 1'b1, 32'hFFFF_FF9C, 32'd7, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
